// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter: round-robin arbiter that lets two immediate consumers share one
// external 12-bit to 32-bit sign extender. For each grant it captures the instruction,
// decodes the format, drives the extender for one cycle, and holds the registered
// result behind a valid/ready port.
module imm_gen_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [XLEN-1:0]    req_instr0,
    input  logic [XLEN-1:0]    req_instr1,
    output logic [11:0]        ext_in,
    input  logic [XLEN-1:0]    ext_out,
    output logic               imm_valid,
    input  logic               imm_ready,
    output logic [XLEN-1:0]    imm_out,
    output logic               imm_id,
    output logic [2:0]         imm_fmt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXTEND = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_INV = 3'b111;

    state_t            state_q, state_d;
    logic              last_q, last_d;        // requester granted most recently
    logic [XLEN-1:0]   instr_q, instr_d;      // instruction captured on accept
    logic              gnt_id_q, gnt_id_d;    // owner of the in-flight request
    logic              imm_valid_q, imm_valid_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              imm_id_q, imm_id_d;
    logic [2:0]        imm_fmt_q, imm_fmt_d;

    logic              can_accept;
    logic              accept;
    logic              gnt_sel;
    logic [2:0]        fmt_dec;
    logic [11:0]       field_dec;
    logic [XLEN-1:0]   imm_dec;

    // Round-robin grant selection and the combinational accept strobe
    always_comb begin
        can_accept = (state_q == IDLE) || ((state_q == HOLD) && imm_ready);
        if (req_valid[0] && req_valid[1]) begin
            gnt_sel = ~last_q;
        end else begin
            gnt_sel = req_valid[1];
        end
        accept    = can_accept && (|req_valid);
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_sel] = 1'b1;
        end
    end

    // Format decode and immediate assembly from the captured instruction
    always_comb begin
        fmt_dec   = FMT_INV;
        field_dec = '0;
        imm_dec   = '0;
        unique case (instr_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                fmt_dec   = FMT_I;
                field_dec = instr_q[31:20];
                imm_dec   = ext_out;
            end
            7'b0100011: begin
                fmt_dec   = FMT_S;
                field_dec = {instr_q[31:25], instr_q[11:7]};
                imm_dec   = ext_out;
            end
            7'b1100011: begin
                fmt_dec   = FMT_B;
                field_dec = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
                imm_dec   = {ext_out[30:0], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_dec = FMT_U;
                imm_dec = {instr_q[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_dec = FMT_J;
                imm_dec = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                           instr_q[20], instr_q[30:21], 1'b0};
            end
            default: begin
                fmt_dec = FMT_INV;
            end
        endcase
        ext_in = (state_q == EXTEND) ? field_dec : '0;
    end

    // Next-state logic: accept, extend, then hold the result until consumed
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        instr_d     = instr_q;
        gnt_id_d    = gnt_id_q;
        imm_valid_d = imm_valid_q;
        imm_d       = imm_q;
        imm_id_d    = imm_id_q;
        imm_fmt_d   = imm_fmt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXTEND;
                end
            end
            EXTEND: begin
                imm_d       = imm_dec;
                imm_id_d    = gnt_id_q;
                imm_fmt_d   = fmt_dec;
                imm_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (imm_ready) begin
                    imm_valid_d = 1'b0;
                    state_d     = accept ? EXTEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            last_d   = gnt_sel;
            gnt_id_d = gnt_sel;
            instr_d  = gnt_sel ? req_instr1 : req_instr0;
        end
    end

    // State and datapath registers; last_q resets to 1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            instr_q     <= '0;
            gnt_id_q    <= 1'b0;
            imm_valid_q <= 1'b0;
            imm_q       <= '0;
            imm_id_q    <= 1'b0;
            imm_fmt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            instr_q     <= instr_d;
            gnt_id_q    <= gnt_id_d;
            imm_valid_q <= imm_valid_d;
            imm_q       <= imm_d;
            imm_id_q    <= imm_id_d;
            imm_fmt_q   <= imm_fmt_d;
        end
    end

    assign imm_valid = imm_valid_q;
    assign imm_out   = imm_q;
    assign imm_id    = imm_id_q;
    assign imm_fmt   = imm_fmt_q;

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Testbench for imm_gen_arbiter: a monitor pushes expected results on each grant and
// pops them when the result is consumed; scenario tasks check timing and control.
module tb_imm_gen_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_instr0;
    logic [31:0] req_instr1;
    logic [11:0] ext_in;
    logic [31:0] ext_out;
    logic        imm_valid;
    logic        imm_ready;
    logic [31:0] imm_out;
    logic        imm_id;
    logic [2:0]  imm_fmt;

    int checks   = 0;
    int failures = 0;

    logic [35:0] sb[$];      // {id, fmt, imm}
    logic        gnt_log[$];

    imm_gen_arbiter #(.XLEN(32), .NUM_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr0(req_instr0), .req_instr1(req_instr1),
        .ext_in(ext_in), .ext_out(ext_out),
        .imm_valid(imm_valid), .imm_ready(imm_ready),
        .imm_out(imm_out), .imm_id(imm_id), .imm_fmt(imm_fmt)
    );

    // Behavioural model of the shared sign extender
    assign ext_out = {{20{ext_in[11]}}, ext_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {fmt, imm} straight from RISC-V immediate definitions
    function automatic logic [34:0] exp_res(input logic [31:0] i);
        logic [31:0] imm;
        logic [2:0]  fmt;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin fmt = 3'b000; imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin fmt = 3'b001; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h63: begin fmt = 3'b010; imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin fmt = 3'b011; imm = {i[31:12], 12'h000}; end
            7'h6F: begin fmt = 3'b100; imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            default: begin fmt = 3'b111; imm = 32'h0; end
        endcase
        return {fmt, imm};
    endfunction

    function automatic logic [11:0] exp_ext(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return i[31:20];
            7'h23: return {i[31:25], i[11:7]};
            7'h63: return {i[31], i[7], i[30:25], i[11:8]};
            default: return 12'h000;
        endcase
    endfunction

    // Scoreboard monitor: push on grant, pop and compare on result handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (imm_valid && imm_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: imm_out=%h id=%0d fmt=%b with no expected entry",
                             imm_out, imm_id, imm_fmt);
                end else begin
                    logic [35:0] e;
                    e = sb.pop_front();
                    if ({imm_id, imm_fmt, imm_out} !== e) begin
                        failures++;
                        $display("FAIL sb_result: got id=%0d fmt=%b imm=%h expected id=%0d fmt=%b imm=%h",
                                 imm_id, imm_fmt, imm_out, e[35], e[34:32], e[31:0]);
                    end
                end
            end
            if (req_ready == 2'b11) begin
                checks++;
                failures++;
                $display("FAIL req_ready_onehot: got %b expected one-hot", req_ready);
            end else if (req_ready == 2'b01) begin
                sb.push_back({1'b0, exp_res(req_instr0)});
                gnt_log.push_back(1'b0);
            end else if (req_ready == 2'b10) begin
                sb.push_back({1'b1, exp_res(req_instr1)});
                gnt_log.push_back(1'b1);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_instr0 = 32'h0;
        req_instr1 = 32'h0;
        imm_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({imm_valid, imm_out, imm_id, imm_fmt, req_ready, ext_in} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b imm=%h id=%b fmt=%b rdy=%b ext=%h expected all zero",
                     imm_valid, imm_out, imm_id, imm_fmt, req_ready, ext_in);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rdy;
        logic       exp_v;
        gnt_log.delete();
        req_instr0 = 32'hFFF00093;
        req_instr1 = 32'hFE20AE23;
        imm_ready  = 1'b1;
        req_valid  = 2'b11;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_v   = (c >= 2) && (c % 2 == 0);
            exp_rdy = (c % 2 != 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (imm_valid !== exp_v || req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_cycle%0d: valid=%b rdy=%b expected valid=%b rdy=%b",
                         c, imm_valid, req_ready, exp_v, exp_rdy);
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        drain();
        checks++;
        if (gnt_log.size() != 4 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1 ||
            gnt_log[2] !== 1'b0 || gnt_log[3] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_order: got %0d grants, expected order 0,1,0,1", gnt_log.size());
        end
    endtask

    task automatic test_formats();
        logic [31:0] tbl [8];
        logic        ids [8];
        tbl = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
                32'h0000007F, 32'h0080006F, 32'h8000A103, 32'hFFDFF06F};
        ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        imm_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (ids[k]) begin
                req_instr1 = tbl[k];
                req_valid  = 2'b10;
            end else begin
                req_instr0 = tbl[k];
                req_valid  = 2'b01;
            end
            @(negedge clk);
            checks++;
            if (req_ready !== (ids[k] ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL fmt%0d_accept: rdy=%b expected %b", k, req_ready,
                         ids[k] ? 2'b10 : 2'b01);
            end
            @(posedge clk); #1;
            req_valid  = 2'b00;
            req_instr0 = 32'hFFFFFFFF;
            req_instr1 = 32'hFFFFFFFF;
            @(negedge clk);
            checks++;
            if (ext_in !== exp_ext(tbl[k]) || imm_valid !== 1'b0) begin
                failures++;
                $display("FAIL fmt%0d_extend: ext_in=%h valid=%b expected ext_in=%h valid=0",
                         k, ext_in, imm_valid, exp_ext(tbl[k]));
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (imm_valid !== 1'b1 || ext_in !== 12'h000) begin
                failures++;
                $display("FAIL fmt%0d_valid: valid=%b ext_in=%h expected valid=1 ext_in=000",
                         k, imm_valid, ext_in);
            end
            @(posedge clk); #1;
        end
        drain();
    endtask

    task automatic test_hold_stall();
        int n;
        imm_ready  = 1'b0;
        req_instr0 = 32'hFFF00093;
        req_valid  = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n = 0;
        while (!imm_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!imm_valid) begin
            failures++;
            $display("FAIL stall_wait: imm_valid=%b expected 1 within 10 cycles", imm_valid);
        end
        req_instr1 = 32'h123450B7;
        req_valid  = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (imm_valid !== 1'b1 || imm_out !== 32'hFFFFFFFF || imm_id !== 1'b0 ||
                imm_fmt !== 3'b000 || req_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall_cycle%0d: valid=%b imm=%h id=%b fmt=%b rdy=%b expected 1 ffffffff 0 000 00",
                         c, imm_valid, imm_out, imm_id, imm_fmt, req_ready);
            end
            @(posedge clk); #1;
        end
        imm_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL stall_release: rdy=%b expected 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
    endtask

    task automatic test_async_reset();
        imm_ready  = 1'b1;
        req_instr0 = 32'hFE000CE3;
        req_valid  = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (ext_in !== 12'hFFC) begin
            failures++;
            $display("FAIL areset_extend: ext_in=%h expected ffc", ext_in);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imm_valid !== 1'b0 || ext_in !== 12'h000 || imm_out !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate: valid=%b ext_in=%h imm=%h expected 0 000 00000000",
                     imm_valid, ext_in, imm_out);
        end
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req_instr0 = 32'hFE000CE3;
        req_instr1 = 32'hFFF00093;
        req_valid  = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL areset_priority: rdy=%b expected 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_formats();
        test_hold_stall();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
